// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmitter and a future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // Widest data word any UART block in this family handles.
    localparam int unsigned MAX_DATA_WIDTH = 9;

    // Number of serial bit periods in one frame (start + data + parity + stop).
    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input int unsigned parity_en,
                                              input int unsigned stop_bits);
        return 1 + data_width + parity_en + stop_bits;
    endfunction

    // Even parity is the XOR of the data bits; odd parity is its complement.
    // Narrow words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input logic                      odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: load to ClksPerBit-1, count down, tick while at zero.
module uart_baud_cnt #(
    parameter int ClksPerBit = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    output logic tick_o
);
    localparam int CntWidth = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntWidth-1:0] LoadVal = CntWidth'(ClksPerBit - 1);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    logic [CntWidth-1:0] cnt_q;

    // Count down from the loaded value and park at zero until reloaded.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LoadVal;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntOne;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed from a FIFO read port; back-to-back frames with no idle gap.
//
// Handshake: a word moves on a rising clk_i edge where s_valid_i and s_ready_o
// are both high. s_ready_o depends only on registered state and reset_i, never
// on s_valid_i; s_data_i is only looked at on that accepting edge.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DataWidth  = 8,
    parameter int ClksPerBit = 16,
    parameter int ParityEn   = 0,
    parameter int ParityOdd  = 0,
    parameter int StopBits   = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DataWidth-1:0] s_data_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);
    if (DataWidth < 5 || DataWidth > 9) begin : g_bad_data_width
        $error("uart_tx_stream: DataWidth must be within 5..9");
    end
    if (ClksPerBit < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_stream: ClksPerBit must be at least 2");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
        $error("uart_tx_stream: StopBits must be 1 or 2");
    end

    localparam int BitWidth = $clog2(DataWidth + 1);
    localparam logic [BitWidth-1:0] BitLast  = BitWidth'(DataWidth - 1);
    localparam logic [BitWidth-1:0] StopLast = BitWidth'(StopBits - 1);
    localparam logic [BitWidth-1:0] BitOne   = BitWidth'(1);

    uart_tx_state_e       state_q, state_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic [BitWidth-1:0]  bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 baud_load;
    logic                 baud_tick;
    logic                 last_stop;
    logic                 accept;

    uart_baud_cnt #(
        .ClksPerBit(ClksPerBit)
    ) u_baud (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (baud_load),
        .tick_o (baud_tick)
    );

    assign last_stop    = (state_q == STOP) && (bit_cnt_q == '0) && baud_tick;
    assign s_ready_o    = ~reset_i & ((state_q == IDLE) | last_stop);
    assign accept       = s_valid_i & s_ready_o;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = last_stop;
    assign tx_o         = tx_q;

    // Next-state, next-bit and timer reload; acceptance overrides the end of a frame.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        baud_load = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = BitLast;
                    baud_load = 1'b1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - BitOne;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else if (ParityEn != 0) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        state_d   = STOP;
                        tx_d      = 1'b1;
                        bit_cnt_d = StopLast;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = StopLast;
                    baud_load = 1'b1;
                end
            end
            STOP: begin
                if (baud_tick && bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - BitOne;
                    tx_d      = 1'b1;
                    baud_load = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (accept) begin
            state_d   = START;
            tx_d      = 1'b0;
            shift_d   = s_data_i;
            parity_d  = parity_bit(MAX_DATA_WIDTH'(s_data_i), ParityOdd != 0);
            bit_cnt_d = '0;
            baud_load = 1'b1;
        end else if (last_stop) begin
            state_d = IDLE;
            tx_d    = 1'b1;
        end
    end

    // State and datapath registers; reset drives the line idle-high at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: three configurations, per-cycle line scoreboard.
module tb_uart_tx_stream;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic [7:0] s_data;
    int         sel;

    logic [2:0] ready_v, tx_v, busy_v, done_v;
    logic       ready_s, tx_s, busy_s, done_s;

    logic [0:0] exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;

    // Per-instance configuration as the bench understands it.
    int pe_cfg[3] = '{0, 1, 1};
    int po_cfg[3] = '{0, 0, 1};
    int sb_cfg[3] = '{1, 2, 1};

    // Clock.
    always #5 clk = ~clk;

    uart_tx_stream #(.DataWidth(8), .ClksPerBit(C), .ParityEn(0), .ParityOdd(0), .StopBits(1)) u_dut (
        .clk_i(clk), .reset_i(reset), .s_valid_i(s_valid && (sel == 0)), .s_ready_o(ready_v[0]),
        .s_data_i(s_data), .tx_o(tx_v[0]), .busy_o(busy_v[0]), .frame_done_o(done_v[0]));

    uart_tx_stream #(.DataWidth(8), .ClksPerBit(C), .ParityEn(1), .ParityOdd(0), .StopBits(2)) u_even (
        .clk_i(clk), .reset_i(reset), .s_valid_i(s_valid && (sel == 1)), .s_ready_o(ready_v[1]),
        .s_data_i(s_data), .tx_o(tx_v[1]), .busy_o(busy_v[1]), .frame_done_o(done_v[1]));

    uart_tx_stream #(.DataWidth(8), .ClksPerBit(C), .ParityEn(1), .ParityOdd(1), .StopBits(1)) u_odd (
        .clk_i(clk), .reset_i(reset), .s_valid_i(s_valid && (sel == 2)), .s_ready_o(ready_v[2]),
        .s_data_i(s_data), .tx_o(tx_v[2]), .busy_o(busy_v[2]), .frame_done_o(done_v[2]));

    assign ready_s = ready_v[sel];
    assign tx_s    = tx_v[sel];
    assign busy_s  = busy_v[sel];
    assign done_s  = done_v[sel];

    task automatic push_bit(input logic b);
        repeat (C) exp_q.push_back(b);
    endtask

    // Expected line level for every cycle of a frame on the selected instance.
    task automatic push_frame(input logic [7:0] d, output int fl);
        logic par;
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(d[i]);
        if (pe_cfg[sel] != 0) begin
            par = (po_cfg[sel] != 0) ? ~(^d) : ^d;
            push_bit(par);
        end
        for (int i = 0; i < sb_cfg[sel]; i++) push_bit(1'b1);
        fl = C * (1 + 8 + pe_cfg[sel] + sb_cfg[sel]);
    endtask

    // Called at a negedge; returns right after the accepting posedge.
    task automatic accept_word(input logic [7:0] d, output bit ok);
        s_data  = d;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ready_s === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
        end else begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: s_ready_o stayed %b, required 1 within 100 cycles", ready_s);
            s_valid = 1'b0;
        end
    endtask

    // Pop and compare one expected line level per cycle, gathering handshake stats.
    task automatic observe(input int n, input int drop_at, input bit scramble, input logic [7:0] next_data,
                           output int busy_n, output int done_n, output int last_done,
                           output int ready_n, output int first_ready);
        logic [0:0] e;
        busy_n = 0; done_n = 0; last_done = 0; ready_n = 0; first_ready = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_underflow: cycle %0d has tx_o=%b, no expected value queued", k, tx_s);
            end else begin
                e = exp_q.pop_front();
                if (tx_s !== e) begin
                    tests_failed++;
                    $display("FAIL tx_line: sel %0d cycle %0d tx_o=%b, required %b", sel, k, tx_s, e);
                end
            end
            if (busy_s === 1'b1) busy_n++;
            if (done_s === 1'b1) begin done_n++; last_done = k; end
            if (k < n && ready_s === 1'b1) begin
                ready_n++;
                if (first_ready == 0) first_ready = k;
            end
            if (k == 1) s_data = next_data;
            if (scramble && k < n - 1) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = 8'($urandom_range(0, 255));
            end else if (k >= drop_at) begin
                s_valid = 1'b0;
            end
        end
    endtask

    // Single frame on the selected instance with busy/frame_done bookkeeping checks.
    task automatic run_frame(input logic [7:0] d, input bit scramble, input string name);
        int fl, b, dn, ld, r, fr;
        bit ok;
        push_frame(d, fl);
        accept_word(d, ok);
        if (ok) begin
            observe(fl, scramble ? fl - 1 : 1, scramble, d, b, dn, ld, r, fr);
            tests_run++;
            if (b !== fl) begin
                tests_failed++;
                $display("FAIL %s_busy: busy_o high %0d cycles, required %0d", name, b, fl);
            end
            tests_run++;
            if (dn !== 1 || ld !== fl) begin
                tests_failed++;
                $display("FAIL %s_done: frame_done_o %0d pulses last at cycle %0d, required 1 at %0d", name, dn, ld, fl);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        sel = 0; s_valid = 1'b1; s_data = 8'h00; reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx_v !== 3'b111 || ready_v !== 3'b000 || busy_v !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_state: tx=%b ready=%b busy=%b, required 111 000 000", tx_v, ready_v, busy_v);
        end
        s_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests_run++;
        if (ready_v !== 3'b111 || tx_v !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b tx=%b, required 111 111", ready_v, tx_v);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        sel = 0;
        run_frame(8'hA5, 1'b0, "single_a5");
    endtask

    task automatic test_back_to_back();
        int fl0, fl1, b, dn, ld, r, fr;
        bit ok;
        sel = 0;
        push_frame(8'h00, fl0);
        push_frame(8'hFF, fl1);
        accept_word(8'h00, ok);
        if (ok) begin
            observe(fl0 + fl1, fl0 + 1, 1'b0, 8'hFF, b, dn, ld, r, fr);
            tests_run++;
            if (r !== 1 || fr !== fl0) begin
                tests_failed++;
                $display("FAIL b2b_ready: s_ready_o high %0d cycles first at %0d, required 1 at %0d", r, fr, fl0);
            end
            tests_run++;
            if (b !== fl0 + fl1 || dn !== 2) begin
                tests_failed++;
                $display("FAIL b2b_busy: busy %0d cycles, %0d done pulses, required %0d and 2", b, dn, fl0 + fl1);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_parity();
        sel = 1;
        run_frame(8'h07, 1'b0, "even_2stop");
        sel = 2;
        run_frame(8'h07, 1'b0, "odd_1stop");
        sel = 1;
        run_frame(8'($urandom_range(0, 255)), 1'b0, "even_rand");
        sel = 0;
    endtask

    task automatic test_random_words();
        sel = 0;
        for (int i = 0; i < 3; i++) run_frame(8'($urandom_range(0, 255)), 1'b0, "rand_word");
    endtask

    task automatic test_reset_mid_frame();
        int fl, b, dn, ld, r, fr;
        logic [0:0] e;
        bit ok;
        sel = 0;
        push_frame(8'h55, fl);
        accept_word(8'h55, ok);
        if (ok) begin
            for (int k = 1; k <= 18; k++) begin
                @(negedge clk);
                if (k == 1) s_valid = 1'b0;
                e = exp_q.pop_front();
                tests_run++;
                if (tx_s !== e) begin
                    tests_failed++;
                    $display("FAIL pre_reset_tx: cycle %0d tx_o=%b, required %b", k, tx_s, e);
                end
            end
            reset = 1'b1;
            #1;
            tests_run++;
            if (tx_s !== 1'b1 || busy_s !== 1'b0 || ready_s !== 1'b0) begin
                tests_failed++;
                $display("FAIL mid_reset: tx=%b busy=%b ready=%b, required 1 0 0", tx_s, busy_s, ready_s);
            end
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (ready_s !== 1'b1 || tx_s !== 1'b1 || busy_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: ready=%b tx=%b busy=%b, required 1 1 0", ready_s, tx_s, busy_s);
        end
        run_frame(8'h3C, 1'b0, "after_reset_3c");
    endtask

    task automatic test_busy_scramble();
        sel = 0;
        run_frame(8'h96, 1'b1, "scramble_96");
        s_valid = 1'b0;
    endtask

    task automatic test_idle();
        int high_n, busy_n;
        sel = 0; s_valid = 1'b0; high_n = 0; busy_n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            s_data = 8'($urandom_range(0, 255));
            if (tx_s === 1'b1) high_n++;
            if (busy_s === 1'b1) busy_n++;
        end
        tests_run++;
        if (high_n !== 100 || busy_n !== 0) begin
            tests_failed++;
            $display("FAIL idle_line: tx high %0d cycles busy %0d, required 100 and 0", high_n, busy_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; s_valid = 1'b0; s_data = 8'h00; reset = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_random_words();
        test_reset_mid_frame();
        test_busy_scramble();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
